tx_arbiter: RTL and testbench

//  Shares one byte-wide UART transmitter among N byte sources (hex encoders, status

---
 rtl/tx_arbiter_pkg.sv | 18 +
 rtl/tx_arbiter_rr_pick.sv | 35 +++
 rtl/tx_arbiter.sv | 89 ++++++++
 tb/tb_tx_arbiter.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_arbiter_pkg.sv
// Shared types and constants for the UART transmit arbiter.
// Owner/pointer indices are sized for the largest supported requester count (8).
package tx_arbiter_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_t;

  localparam int BYTE_W  = 8;
  localparam int MAX_REQ = 8;
  localparam int IDX_W   = 3;

  function automatic int wrap_idx(input int base, input int step, input int n);
    return (base + step) % n;
  endfunction

endpackage

// File: rtl/tx_arbiter_rr_pick.sv
// Combinational one-hot selector: round-robin starting after ptr when mode=1,
// lowest set index when mode=0.
module rr_pick
  import tx_arbiter_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  input  logic             mode,
  output logic [N-1:0]     onehot,
  output logic [IDX_W-1:0] idx
);

  always_comb begin
    logic found;
    int   cand;
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    cand   = 0;
    for (int k = 0; k < N; k++) begin
      cand = mode ? wrap_idx(int'(ptr), k + 1, N) : k;
      // Equality scan keeps every select a constant index.
      for (int j = 0; j < N; j++) begin
        if (!found && (j == cand) && req[j]) begin
          found     = 1'b1;
          onehot[j] = 1'b1;
          idx       = IDX_W'(j);
        end
      end
    end
  end

endmodule

// File: rtl/tx_arbiter.sv
// Shares one byte-wide UART transmitter among N_REQ sources; a grant is held for
// the whole message, i.e. for as long as the owner keeps its tx_en high.
module tx_arbiter
  import tx_arbiter_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int RR    = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_tx_en,
  input  logic [BYTE_W*N_REQ-1:0] req_tx_data,
  output logic [N_REQ-1:0]        req_tx_ack,
  output logic                    tx_en,
  output logic [BYTE_W-1:0]       tx_data,
  input  logic                    tx_ack,
  output logic [N_REQ-1:0]        grant,
  output logic                    busy
);

  localparam logic             RR_MODE = (RR != 0);
  localparam logic [IDX_W-1:0] PTR_RST = IDX_W'(N_REQ - 1);

  arb_state_t       state;
  logic [IDX_W-1:0] owner;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] pick_idx;
  logic [N_REQ-1:0] pick_onehot;
  logic             owner_en;

  rr_pick #(
    .N(N_REQ)
  ) u_pick (
    .req   (req_tx_en),
    .ptr   (ptr),
    .mode  (RR_MODE),
    .onehot(pick_onehot),
    .idx   (pick_idx)
  );

  // Release only when the owner drops tx_en; byte count never matters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      grant <= '0;
      owner <= '0;
      ptr   <= PTR_RST;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|req_tx_en) begin
            state <= ST_GRANT;
            grant <= pick_onehot;
            owner <= pick_idx;
          end
        end
        ST_GRANT: begin
          if (!owner_en) begin
            state <= ST_IDLE;
            grant <= '0;
            ptr   <= owner;
          end
        end
        default: begin
          state <= ST_IDLE;
          grant <= '0;
        end
      endcase
    end
  end

  assign busy     = (state == ST_GRANT);
  assign owner_en = |(req_tx_en & grant);
  assign tx_en    = busy & owner_en;

  always_comb begin
    tx_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) tx_data = req_tx_data[BYTE_W*i +: BYTE_W];
    end
  end

  // Acks reach only the owner, and only while it actually presents a byte.
  assign req_tx_ack = (tx_en & tx_ack) ? grant : '0;

  grant_onehot_a: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant));
  grant_busy_a:   assert property (@(posedge clk) disable iff (!rst_n) busy == (grant != '0));

endmodule

// File: tb/tb_tx_arbiter.sv
// Randomised and directed bench for tx_arbiter with a rule-level reference model
// and a per-source byte scoreboard; a second instance covers fixed priority.
`timescale 1ns/1ps
module tb_tx_arbiter;
  localparam int N = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  req_tx_en, req_tx_ack, grant;
  logic [23:0] req_tx_data;
  logic        tx_en, tx_ack, busy;
  logic [7:0]  tx_data;

  logic [2:0]  fp_req_tx_en, fp_req_tx_ack, fp_grant;
  logic [23:0] fp_req_tx_data;
  logic        fp_tx_en, fp_tx_ack, fp_busy;
  logic [7:0]  fp_tx_data;

  initial forever #5 clk = ~clk;

  tx_arbiter #(.N_REQ(N), .RR(1)) dut (
    .clk(clk), .rst_n(rst_n), .req_tx_en(req_tx_en), .req_tx_data(req_tx_data),
    .req_tx_ack(req_tx_ack), .tx_en(tx_en), .tx_data(tx_data), .tx_ack(tx_ack),
    .grant(grant), .busy(busy));

  tx_arbiter #(.N_REQ(N), .RR(0)) dut_fp (
    .clk(clk), .rst_n(rst_n), .req_tx_en(fp_req_tx_en), .req_tx_data(fp_req_tx_data),
    .req_tx_ack(fp_req_tx_ack), .tx_en(fp_tx_en), .tx_data(fp_tx_data), .tx_ack(fp_tx_ack),
    .grant(fp_grant), .busy(fp_busy));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard entries are {source[2:0], byte[7:0]}; order matters per source only.
  logic [10:0] exp_q[$];
  int          line_log[$];

  // Reference model: who owns the line, from the arbitration rules.
  bit m_busy;
  int m_owner, m_ptr;

  always @(negedge clk) begin
    logic       exp_en;
    logic [2:0] exp_grant;
    int         hit;
    if (!rst_n) begin
      m_busy  = 1'b0;
      m_owner = 0;
      m_ptr   = N - 1;
      chk("reset_outputs", 32'({tx_en, busy, grant, req_tx_ack}), 32'h0);
    end else begin
      exp_en    = m_busy && bit'(req_tx_en >> m_owner);
      exp_grant = m_busy ? 3'(1 << m_owner) : 3'b000;
      chk("grant", 32'(grant), 32'(exp_grant));
      chk("busy", 32'(busy), 32'(m_busy));
      chk("tx_en", 32'(tx_en), 32'(exp_en));
      if (exp_en) chk("tx_data", 32'(tx_data), 32'(8'(req_tx_data >> (8 * m_owner))));
      chk("req_tx_ack", 32'(req_tx_ack), 32'((exp_en && tx_ack) ? exp_grant : 3'b000));
      if (exp_en && tx_ack) begin
        hit = -1;
        foreach (exp_q[k]) if (hit < 0 && int'(exp_q[k][10:8]) == m_owner) hit = k;
        if (hit < 0) begin
          chk("sb_unexpected_byte_src", 32'(m_owner), 32'hFF);
        end else begin
          chk("sb_byte", 32'({3'(m_owner), tx_data}), 32'(exp_q[hit]));
          exp_q.delete(hit);
        end
        line_log.push_back(m_owner);
      end
      if (m_busy) begin
        if (!bit'(req_tx_en >> m_owner)) begin
          m_busy = 1'b0;
          m_ptr  = m_owner;
        end
      end else if (req_tx_en != 3'b000) begin
        for (int k = 1; k <= N; k++) begin
          if (!m_busy && bit'(req_tx_en >> ((m_ptr + k) % N))) begin
            m_owner = (m_ptr + k) % N;
            m_busy  = 1'b1;
          end
        end
      end
    end
  end

  // Source and UART behaviour
  logic [7:0] mb[N][4];
  int         mlen[N], mpos[N], hold[N];
  bit         act[N];
  bit         src_auto, src_rand, src_cont, uart_on, spurious_on;
  int         uart_delay, uart_cnt, msgs_left;
  logic [2:0] ack_s;
  logic       txen_s;

  task automatic start_msg(input int i, input int len, input logic [31:0] bytes);
    for (int k = 0; k < len; k++) begin
      mb[i][k] = bytes[8*k +: 8];
      exp_q.push_back({3'(i), bytes[8*k +: 8]});
    end
    mlen[i] = len;
    mpos[i] = 0;
    act[i]  = 1'b1;
  endtask

  task automatic drive_sources();
    logic [2:0]  en;
    logic [23:0] d;
    en = '0;
    d  = '0;
    for (int i = 0; i < N; i++) begin
      if (act[i]) begin
        en[i]      = 1'b1;
        d[8*i +: 8] = mb[i][mpos[i]];
      end
    end
    req_tx_en   = en;
    req_tx_data = d;
  endtask

  task automatic update_sources();
    for (int i = 0; i < N; i++) begin
      if (act[i]) begin
        if (ack_s[i]) begin
          mpos[i]++;
          if (mpos[i] == mlen[i]) begin
            act[i]  = 1'b0;
            hold[i] = src_cont ? 0 : int'($urandom_range(0, 3));
          end
        end
      end else if (hold[i] > 0) begin
        hold[i]--;
      end else if (src_cont) begin
        start_msg(i, 1, $urandom);
      end else if (src_rand && msgs_left > 0 && $urandom_range(0, 1) == 1) begin
        msgs_left--;
        start_msg(i, int'($urandom_range(1, 3)), $urandom);
      end
    end
  endtask

  function automatic int next_delay();
    return (uart_delay >= 0) ? uart_delay : int'($urandom_range(0, 3));
  endfunction

  task automatic update_uart();
    if (!uart_on) begin
      tx_ack = 1'b0;
    end else if (tx_ack) begin
      tx_ack   = 1'b0;
      uart_cnt = next_delay();
    end else if (txen_s) begin
      if (uart_cnt <= 0) tx_ack = 1'b1;
      else uart_cnt--;
    end else begin
      uart_cnt = next_delay();
      tx_ack   = spurious_on && ($urandom_range(0, 7) == 0);
    end
  endtask

  task automatic step();
    @(negedge clk);
    ack_s  = req_tx_ack;
    txen_s = tx_en;
    @(posedge clk);
    #1;
    if (src_auto) begin
      update_sources();
      drive_sources();
    end
    update_uart();
  endtask

  function automatic bit any_act();
    bit a;
    a = 1'b0;
    for (int i = 0; i < N; i++) a = a | act[i];
    return a;
  endfunction

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while ((any_act() || exp_q.size() != 0) && n < budget) begin
      step();
      n++;
    end
    step();
    step();
    chk(name, 32'(exp_q.size()), 32'h0);
  endtask

  task automatic check_log(input string name, input int n, input logic [31:0] seq);
    for (int k = 0; k < n; k++)
      chk(name, (k < line_log.size()) ? 32'(line_log[k]) : 32'hFFFF, 32'(seq[4*k +: 4]));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int seq[$];
    logic       prev_busy;
    logic [2:0] fp_ack_s;

    src_auto = 0; src_rand = 0; src_cont = 0; uart_on = 0; spurious_on = 0;
    uart_delay = 0; uart_cnt = 0; msgs_left = 0; ack_s = '0; txen_s = 1'b0;
    for (int i = 0; i < N; i++) begin act[i] = 0; hold[i] = 0; mlen[i] = 0; mpos[i] = 0; end
    fp_req_tx_en = '0; fp_req_tx_data = '0; fp_tx_ack = 1'b0;

    // Reset with every source requesting and a stray ack
    rst_n = 1'b0; req_tx_en = 3'b111; req_tx_data = 24'hA5A5A5; tx_ack = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_tx_en", 32'(tx_en), 32'h0);
    chk("reset_grant", 32'(grant), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_req_tx_ack", 32'(req_tx_ack), 32'h0);
    rst_n = 1'b1; req_tx_en = '0; req_tx_data = '0; tx_ack = 1'b0;
    step();

    // Single two-byte message from src1, UART takes each byte after 3 cycles
    src_auto = 1; uart_on = 1; uart_delay = 3;
    line_log.delete();
    start_msg(1, 2, 32'h0000_4134);
    drive_sources();
    step();
    chk("arb_latency_tx_en", 32'(tx_en), 32'h1);
    chk("single_grant", 32'(grant), 32'h2);
    drain("single_drain", 100);
    check_log("single_order", 2, 32'h0000_0011);

    // Atomicity: src0 then src1 two cycles later
    uart_delay = 1;
    line_log.delete();
    start_msg(0, 2, 32'h0000_B1B0);
    drive_sources();
    step();
    step();
    start_msg(1, 2, 32'h0000_C1C0);
    drive_sources();
    drain("atomic_drain", 100);
    check_log("atomic_order", 4, 32'h0000_1100);

    // Round-robin with all sources requesting continuously, from a fresh reset
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    line_log.delete();
    uart_delay = 0;
    src_cont = 1;
    for (int c = 0; c < 200 && line_log.size() < 4; c++) step();
    src_cont = 0;
    drain("rr_drain", 200);
    check_log("rr_sequence", 4, 32'h0000_0210);

    // Abandon: src2 granted, drops before any ack
    line_log.delete();
    start_msg(0, 1, 32'h0000_005A);
    drive_sources();
    drain("pre_abandon_drain", 100);
    line_log.delete();
    src_auto = 0; uart_on = 0; tx_ack = 1'b0;
    req_tx_en = 3'b100; req_tx_data = 24'h77_0000;
    step();
    chk("abandon_grant", 32'(grant), 32'h4);
    step();
    req_tx_en = 3'b000;
    step();
    chk("abandon_busy", 32'(busy), 32'h0);
    chk("abandon_no_bytes", 32'(line_log.size()), 32'h0);
    req_tx_en = 3'b011; req_tx_data = 24'h00_2211;
    step();
    chk("abandon_ptr_next", 32'(grant), 32'h1);
    req_tx_en = 3'b000;
    step();
    step();

    // Spurious ack while idle, then reset mid-grant
    tx_ack = 1'b1;
    #1;
    chk("spurious_ack", 32'(req_tx_ack), 32'h0);
    step();
    chk("spurious_busy", 32'(busy), 32'h0);
    req_tx_en = 3'b010; req_tx_data = 24'h00_6600;
    step();
    chk("pre_reset_grant", 32'(grant), 32'h2);
    step();
    rst_n = 1'b0;
    #1;
    chk("async_reset_tx_en", 32'(tx_en), 32'h0);
    chk("async_reset_grant", 32'(grant), 32'h0);
    chk("async_reset_busy", 32'(busy), 32'h0);
    step();
    req_tx_en = 3'b011;
    rst_n = 1'b1;
    step();
    chk("post_reset_winner", 32'(grant), 32'h1);
    req_tx_en = 3'b000;
    step();
    step();

    // Randomised traffic with random UART latency and spurious acks
    line_log.delete();
    src_auto = 1; src_rand = 1; uart_on = 1; uart_delay = -1; spurious_on = 1;
    msgs_left = 150;
    for (int c = 0; c < 3000 && msgs_left > 0; c++) step();
    src_rand = 0;
    drain("random_drain", 500);
    chk("random_bytes_seen", 32'(line_log.size() > 150), 32'h1);
    spurious_on = 0; uart_on = 0; src_auto = 0;
    step();

    // Fixed priority instance, all sources requesting continuously
    fp_ack_s = '0;
    prev_busy = 1'b0;
    for (int c = 0; c < 60 && seq.size() < 3; c++) begin
      fp_req_tx_en   = ~fp_ack_s;
      fp_req_tx_data = 24'h0F0E0D;
      #1;
      fp_tx_ack = fp_tx_en;
      @(negedge clk);
      if (fp_busy && !prev_busy) seq.push_back(int'(fp_grant));
      prev_busy = fp_busy;
      fp_ack_s  = fp_req_tx_ack;
      @(posedge clk);
      #1;
    end
    for (int k = 0; k < 3; k++)
      chk("fixed_prio_grant", (k < seq.size()) ? 32'(seq[k]) : 32'hFFFF, 32'h1);
    fp_req_tx_en = '0;
    fp_tx_ack = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
